// File: rtl/rvx_spi_subordinate_pkg.sv
// Shared constants, state encoding and edge-select helper for the SPI subordinate.
package rvx_spi_subordinate_pkg;

  localparam logic [4:0] RVX_SPI_SUB_MODE_REG_ADDR   = 5'h00;
  localparam logic [4:0] RVX_SPI_SUB_TX_REG_ADDR     = 5'h04;
  localparam logic [4:0] RVX_SPI_SUB_RX_REG_ADDR     = 5'h08;
  localparam logic [4:0] RVX_SPI_SUB_STATUS_REG_ADDR = 5'h0C;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_sub_state_e;

  // Data is sampled on the falling SCLK edge when exactly one of cpol/cpha is set.
  function automatic logic sample_on_fall(input logic cpol, input logic cpha);
    return cpol ^ cpha;
  endfunction

endpackage

// File: rtl/rvx_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin with registered rise/fall pulses.
// level_o is delayed to line up with the pulses, so a data pin run through
// an identical instance is seen at the same instant as the clock pin's edge.
module rvx_sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise_q;
  logic       fall_q;

  // Synchronize the pin, keep the previous value and register the edge pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
      fall_q <= ~sync_q[1] & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/rvx_spi_subordinate.sv
// SPI subordinate: byte exchange between an external SPI manager and the CPU,
// one byte buffered in each direction, CPU access over the RVX IO register port.
module rvx_spi_subordinate
  import rvx_spi_subordinate_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs,
  output logic        miso
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_lvl;
  logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;
  logic [23:0] unused_wdata;

  rvx_sync_edge u_sync_sclk (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (sclk),
    .level_o (unused_sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  rvx_sync_edge u_sync_mosi (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (mosi),
    .level_o (mosi_lvl),
    .rise_o  (unused_mosi_rise),
    .fall_o  (unused_mosi_fall)
  );

  rvx_sync_edge u_sync_cs (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (cs),
    .level_o (unused_cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  assign unused_wdata = write_data[31:8];

  spi_sub_state_e state_q;
  logic [1:0]  mode_q;
  logic [7:0]  tx_buf_q;
  logic        tx_full_q;
  logic [7:0]  rx_buf_q;
  logic        rx_valid_q;
  logic        overrun_q;
  logic [7:0]  shift_tx_q;
  logic [7:0]  shift_rx_q;
  logic [2:0]  bit_cnt_q;
  logic        miso_q;
  logic [31:0] read_data_q;
  logic        read_response_q;
  logic        write_response_q;

  logic        cpha, cpol;
  logic        sample_pulse, shift_pulse;
  logic        wr_ok, wr_tx, wr_mode, rd_rx;
  logic [7:0]  load_byte;
  logic [7:0]  rx_next;
  logic [31:0] rd_word;

  assign cpha = mode_q[0];
  assign cpol = mode_q[1];

  assign sample_pulse = sample_on_fall(cpol, cpha) ? sclk_fall : sclk_rise;
  assign shift_pulse  = sample_on_fall(cpol, cpha) ? sclk_rise : sclk_fall;

  assign wr_ok   = write_request && ((write_strobe == 4'b1111) ||
                                     (write_strobe == 4'b0011) ||
                                     (write_strobe == 4'b0001));
  assign wr_tx   = wr_ok && (rw_address == RVX_SPI_SUB_TX_REG_ADDR);
  assign wr_mode = wr_ok && (rw_address == RVX_SPI_SUB_MODE_REG_ADDR) && (state_q == ST_IDLE);
  assign rd_rx   = read_request && (rw_address == RVX_SPI_SUB_RX_REG_ADDR);

  // An empty tx buffer shifts out zeros.
  assign load_byte = tx_full_q ? tx_buf_q : 8'h00;
  assign rx_next   = {shift_rx_q[6:0], mosi_lvl};

  // Register read mux; unmapped addresses read as zero.
  always_comb begin
    rd_word = 32'h0;
    case (rw_address)
      RVX_SPI_SUB_MODE_REG_ADDR:   rd_word = {30'h0, mode_q};
      RVX_SPI_SUB_TX_REG_ADDR:     rd_word = {24'h0, tx_buf_q};
      RVX_SPI_SUB_RX_REG_ADDR:     rd_word = {24'h0, rx_buf_q};
      RVX_SPI_SUB_STATUS_REG_ADDR: rd_word = {28'h0, overrun_q, tx_full_q, rx_valid_q,
                                              state_q == ST_ACTIVE};
      default:                     rd_word = 32'h0;
    endcase
  end

  // Frame FSM, shift registers, buffers/flags and the CPU register port.
  // With cpha=0 the next bit goes out at every (re)load and on shift edges in
  // between; shift_tx_q then holds the bits still to be presented.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      mode_q           <= 2'b00;
      tx_buf_q         <= 8'h00;
      tx_full_q        <= 1'b0;
      rx_buf_q         <= 8'h00;
      rx_valid_q       <= 1'b0;
      overrun_q        <= 1'b0;
      shift_tx_q       <= 8'h00;
      shift_rx_q       <= 8'h00;
      bit_cnt_q        <= 3'd0;
      miso_q           <= 1'b0;
      read_data_q      <= 32'h0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
    end else begin
      read_response_q  <= read_request;
      write_response_q <= write_request;
      if (read_request) read_data_q <= rd_word;
      if (wr_mode) mode_q <= write_data[1:0];
      if (wr_tx) tx_buf_q <= write_data[7:0];
      if (rd_rx) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          miso_q    <= 1'b0;
          bit_cnt_q <= 3'd0;
          if (cs_fall) begin
            state_q    <= ST_ACTIVE;
            tx_full_q  <= 1'b0;
            shift_tx_q <= cpha ? load_byte : {load_byte[6:0], 1'b0};
            miso_q     <= cpha ? 1'b0 : load_byte[7];
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            miso_q    <= 1'b0;
          end else if (sample_pulse) begin
            shift_rx_q <= rx_next;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q  <= 3'd0;
              rx_buf_q   <= rx_next;
              rx_valid_q <= 1'b1;
              overrun_q  <= rd_rx ? 1'b0 : (overrun_q | rx_valid_q);
              tx_full_q  <= 1'b0;
              shift_tx_q <= cpha ? load_byte : {load_byte[6:0], 1'b0};
              if (!cpha) miso_q <= load_byte[7];
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else if (shift_pulse && (cpha || (bit_cnt_q != 3'd0))) begin
            miso_q     <= shift_tx_q[7];
            shift_tx_q <= {shift_tx_q[6:0], 1'b0};
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A CPU write to TX wins over a same-cycle reload clearing the flag.
      if (wr_tx) tx_full_q <= 1'b1;
    end
  end

  assign read_data      = read_data_q;
  assign read_response  = read_response_q;
  assign write_response = write_response_q;
  // Quiet the line as soon as the manager deselects, ahead of the synchronizer.
  assign miso           = miso_q & ~cs;

endmodule
